// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-control definitions: state encodings and defaults used by the core,
// the emulator bench and the run-control stage.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HALT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_STEP  = 2'd3
    } run_state_t;

    localparam int unsigned CNT_W_DEF = 16;

    // States in which the divider runs and clock enables may be issued.
    function automatic logic is_active(run_state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the clock.
module cpu_run_ctrl_reset_sync (
    input  logic clock,
    input  logic arst_n,
    output logic sync_rst_n
);

    logic meta;
    logic held;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            meta <= 1'b0;
            held <= 1'b0;
        end else begin
            meta <= 1'b1;
            held <= meta;
        end
    end

    assign sync_rst_n = held;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control stage for the BJT CPU core: stretched core reset, divided clock
// enable, run/halt/single-step FSM and a saturating count of issued enables.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_STRETCH = 4,
    parameter int unsigned DIV_W       = 4,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_halt_req,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_cpu_reset,
    output logic             o_cpu_ce,
    output logic             o_step_ack,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int unsigned SW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [SW-1:0] STRETCH_LAST = SW'(RST_STRETCH - 1);

    logic             rst_n;
    run_state_t       state;
    run_state_t       state_next;
    logic [SW-1:0]    stretch_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_next;
    logic             ce;
    logic             ce_next;
    logic             ack;
    logic             ack_next;
    logic             step_q;
    logic             step_rise;
    logic [CNT_W-1:0] cycle_cnt;

    cpu_run_ctrl_reset_sync u_reset_sync (
        .clock      (i_clock),
        .arst_n     (i_reset_n),
        .sync_rst_n (rst_n)
    );

    assign step_rise = i_step & ~step_q;

    // The enable is registered, so the divider predicts next cycle's tick from the
    // count it is about to hold; ce itself marks the current tick cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_RESET: if (stretch_cnt == STRETCH_LAST) state_next = i_run ? ST_RUN : ST_HALT;
            ST_RUN:   if (i_halt_req || !i_run)        state_next = ST_HALT;
            ST_HALT: begin
                if (step_rise)  state_next = ST_STEP;
                else if (i_run) state_next = ST_RUN;
            end
            ST_STEP:  if (ce)                          state_next = ST_HALT;
        endcase

        div_cnt_next = '0;
        if (is_active(state) && is_active(state_next) && !ce)
            div_cnt_next = div_cnt + 1'b1;

        ce_next  = is_active(state_next) && (div_cnt_next >= i_div);
        ack_next = ce_next && (state_next == ST_STEP);
    end

    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            stretch_cnt <= '0;
            div_cnt     <= '0;
            ce          <= 1'b0;
            ack         <= 1'b0;
            step_q      <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
            ce      <= ce_next;
            ack     <= ack_next;
            step_q  <= i_step;
            if (state == ST_RESET && stretch_cnt != STRETCH_LAST)
                stretch_cnt <= stretch_cnt + 1'b1;
            if (ce && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign o_cpu_reset = (state == ST_RESET);
    assign o_cpu_ce    = ce;
    assign o_step_ack  = ack;
    assign o_state     = state;
    assign o_cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a CE scoreboard: stimulus queues the
// expected enables, a negedge monitor checks every enable the DUT issues.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    typedef struct {
        int cyc;
        int st;
        int ack;
        int cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        halt_req;
    logic [3:0]  div;

    logic        cpu_reset, cpu_ce, step_ack;
    logic [1:0]  state;
    logic [15:0] cycle_cnt;
    logic        cpu_reset4, cpu_ce4, step_ack4;
    logic [1:0]  state4;
    logic [3:0]  cycle_cnt4;

    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    exp_t q[$];

    cpu_run_ctrl dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_run       (run),
        .i_step      (step),
        .i_halt_req  (halt_req),
        .i_div       (div),
        .o_cpu_reset (cpu_reset),
        .o_cpu_ce    (cpu_ce),
        .o_step_ack  (step_ack),
        .o_state     (state),
        .o_cycle_cnt (cycle_cnt)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_run       (run),
        .i_step      (step),
        .i_halt_req  (halt_req),
        .i_div       (div),
        .o_cpu_reset (cpu_reset4),
        .o_cpu_ce    (cpu_ce4),
        .o_step_ack  (step_ack4),
        .o_state     (state4),
        .o_cycle_cnt (cycle_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns 1 ns after rising edge number c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ce(input int c, input int st, input int ack);
        q.push_back('{c, st, ack, exp_cnt});
        exp_cnt++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (step_ack) chk("ack_has_ce", int'(cpu_ce), 1);
        if (cpu_ce) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ce: got CE at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("ce_cycle", cyc, e.cyc);
                chk("ce_state", int'(state), e.st);
                chk("ce_ack", int'(step_ack), e.ack);
                chk("ce_cycle_cnt", int'(cycle_cnt), e.cnt);
            end
        end
    end

    initial begin
        #3000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected end by cycle 100", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; div = 4'd0;

        // Reset released after edge 3: 2 sync + 4 stretch edges, leaves RESET at edge 9
        for (int c = 1; c <= 9; c++) begin
            goto(c);
            if (c == 3) rst_n = 1'b1;
            @(negedge clk);
            chk("rst_cpu_reset", int'(cpu_reset), (c < 9) ? 1 : 0);
            chk("rst_state", int'(state), (c < 9) ? 0 : 1);
            chk("rst_ce", int'(cpu_ce), 0);
            if (c == 1) chk("rst_cycle_cnt", int'(cycle_cnt), 0);
        end

        // Free run, divide by 1: ten back-to-back enables
        goto(10); run = 1'b1; div = 4'd0;
        for (int k = 0; k < 10; k++) push_ce(11 + k, 2, 0);
        goto(20); run = 1'b0;
        goto(21); @(negedge clk);
        chk("div1_state", int'(state), 1);
        chk("div1_cycle_cnt", int'(cycle_cnt), 10);
        chk("div1_cycle_cnt4", int'(cycle_cnt4), 10);

        // Divide by 4, then lower the ratio while the count is 2
        goto(22); run = 1'b1; div = 4'd3;
        for (int k = 0; k < 4; k++) push_ce(26 + 4 * k, 2, 0);
        goto(41); div = 4'd1;
        push_ce(42, 2, 0);
        push_ce(44, 2, 0);
        goto(44); run = 1'b0;
        goto(45); @(negedge clk);
        chk("div4_state", int'(state), 1);

        // Single step with divide by 3; i_step stays high afterwards
        goto(46); div = 4'd2; step = 1'b1;
        push_ce(49, 3, 1);
        goto(50); @(negedge clk);
        chk("step_done_state", int'(state), 1);
        goto(56); step = 1'b0;

        // Halt request on a tick cycle while i_run stays high
        goto(57); run = 1'b1; div = 4'd1;
        push_ce(59, 2, 0);
        push_ce(61, 2, 0);
        goto(61); halt_req = 1'b1;
        goto(62); halt_req = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("halt_req_state", int'(state), 1);

        // Asynchronous reset during the enable cycle of a step
        goto(64); div = 4'd2; step = 1'b1;
        goto(67);
        chk("pre_reset_ce", int'(cpu_ce), 1);
        chk("pre_reset_ack", int'(step_ack), 1);
        chk("pre_reset_state", int'(state), 3);
        rst_n = 1'b0; step = 1'b0;
        #1;
        chk("async_ce", int'(cpu_ce), 0);
        chk("async_cpu_reset", int'(cpu_reset), 1);
        chk("async_state", int'(state), 0);
        chk("async_ack", int'(step_ack), 0);
        chk("async_cycle_cnt", int'(cycle_cnt), 0);
        exp_cnt = 0;

        // Release straight into RUN, 20 enables: the 4-bit counter saturates
        goto(70); rst_n = 1'b1; run = 1'b1; div = 4'd0;
        for (int k = 0; k < 20; k++) push_ce(76 + k, 2, 0);
        goto(75); @(negedge clk);
        chk("rel_cpu_reset_held", int'(cpu_reset), 1);
        goto(76); @(negedge clk);
        chk("rel_cpu_reset_drop", int'(cpu_reset), 0);
        chk("rel_state_run", int'(state), 2);
        goto(95); run = 1'b0;
        goto(96); @(negedge clk);
        chk("sat_cycle_cnt", int'(cycle_cnt), 20);
        chk("sat_cycle_cnt4", int'(cycle_cnt4), 15);
        chk("sat_state", int'(state), 1);

        goto(100);
        chk("pending_ce", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
